mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/writeback.
//  Drives all enables and mux selects (alusrcb, pcsrc into 3/4:1 muxes), plus aluop to the ALU decoder.
//  Sits beside the datapath in the top-level controller.
//  Adds a memory-ready wait handshake and a retired-instruction counter.
// PARAMETERS
//  WAIT_EN  1   1: honour mem_ready; 0: mem_ready treated as constant 1
//  CNT_W    32  width of instret counter
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high; sampled on rising clk edge
//  op         in   6      instr[31:26] from instruction register
//  mem_ready  in   1      memory completes access this cycle
//  pcwrite    out  1      unconditional PC write
//  branch     out  1      conditional PC write (datapath ANDs with zero)
//  iord       out  1      address mux: 0=PC, 1=ALUOut
//  memwrite   out  1      memory write strobe
//  irwrite    out  1      instruction register load
//  regdst     out  1      0=rt, 1=rd
//  memtoreg   out  1      0=ALUOut, 1=Data
//  regwrite   out  1      register file write
//  alusrca    out  1      0=PC, 1=A
//  alusrcb    out  2      00=B 01=4 10=SignImm 11=SignImm<<2
//  pcsrc      out  2      00=ALUResult 01=ALUOut 10=jump target
//  aluop      out  2      00=add 01=sub 10=funct
//  retire     out  1      1-cycle pulse on last cycle of each legal instruction
//  illegal    out  1      1-cycle pulse in DECODE on unsupported op
//  instret    out  CNT_W  count of retire pulses, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset: state=FETCH, instret=0; all outputs are decoded from state, so in the cycle after reset
//    they are the FETCH values (irwrite/pcwrite gated by mem_ready). reset mid-instruction aborts it,
//    no retire.
//  - Outputs Moore-decoded from state; all unlisted outputs are 0 in each state:
//    FETCH: alusrcb=01, irwrite=pcwrite=mem_ready; advance to DECODE only if mem_ready, else hold.
//    DECODE: alusrcb=11. op 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX,
//      001000->ADDIEX, 000010->JEX, other->FETCH with illegal=1.
//    MEMADR: alusrca=1, alusrcb=10. lw->MEMRD, sw->MEMWR.
//    MEMRD: iord=1; hold until mem_ready, then MEMWB.
//    MEMWB: memtoreg=1, regwrite=1, retire=1 -> FETCH.
//    MEMWR: iord=1, memwrite=1; hold until mem_ready; on mem_ready retire=1 -> FETCH.
//    RTYPEEX: alusrca=1, aluop=10 -> RTYPEWB. RTYPEWB: regdst=1, regwrite=1, retire=1 -> FETCH.
//    BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1, retire=1 -> FETCH.
//    ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB. ADDIWB: regwrite=1, retire=1 -> FETCH.
//    JEX: pcsrc=10, pcwrite=1, retire=1 -> FETCH.
//  - op sampled only in DECODE/MEMADR (IR is stable then); op changes elsewhere are ignored.
//  - Any unencoded state -> FETCH next cycle, outputs all 0.
//  - instret increments on retire; all-ones wraps to 0. reset takes priority over increment.
//  - Latency (mem_ready=1): lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles; each wait cycle adds 1.
// STRUCTURE
//  - mc_ctrl_pkg: statetype_t enum (12 states), OP_LW/OP_SW/OP_RTYPE/OP_BEQ/OP_ADDI/OP_J,
//    ALUOP_ADD/SUB/FUNCT, ALUSRCB_*/PCSRC_* encodings.
//  - Sub-module mc_ctrl_outdec: combinational state(+mem_ready) -> control word.
//  - Top holds state register, next-state logic, instret counter.
// TESTING
//  - reset=1 2 cycles, mem_ready=1 -> state FETCH, irwrite=pcwrite=1, alusrcb=01, instret=0.
//  - op=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite+memtoreg+retire in cycle 5.
//  - op=101011, mem_ready low 3 cycles in MEMWR -> memwrite,iord held 4 cycles; single retire.
//  - op=000100 -> BEQEX with branch=1, pcsrc=01, aluop=01; op=000010 -> JEX pcwrite=1, pcsrc=10.
//  - op=111111 -> illegal pulse in DECODE, back to FETCH, instret unchanged.
//  - CNT_W=4, 16 R-type instrs -> instret wraps 15->0; reset asserted in RTYPEEX -> FETCH, no retire.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings and control-word layout for the multicycle MIPS controller.
package mc_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype_t;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] ALUSRCB_B     = 2'b00;
  localparam logic [SEL_W-1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALURES = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  // Full control word driven toward the datapath each cycle.
  typedef struct packed {
    logic             pcwrite;
    logic             branch;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             regdst;
    logic             memtoreg;
    logic             regwrite;
    logic             alusrca;
    logic [SEL_W-1:0] alusrcb;
    logic [SEL_W-1:0] pcsrc;
    logic [SEL_W-1:0] aluop;
    logic             retire;
    logic             illegal;
  } ctrl_t;

  // True for every opcode this controller knows how to execute.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Control-word decoder: current state (plus memory handshake) to datapath controls.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  statetype_t        state,
  input  logic              mem_ready,
  input  logic [OP_W-1:0]   op,
  output ctrl_t             ctrl
);

  // Per-state control decode; anything not set stays 0, unencoded states drive all 0.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = ALUSRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = ALUSRCB_IMMSH;
        ctrl.illegal = ~op_legal(op);
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      MEMRD: begin
        ctrl.iord = 1'b1;
      end
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.retire   = mem_ready;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
        ctrl.retire  = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
        ctrl.retire  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: state sequencing, memory wait, retired-instruction count.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit          WAIT_EN = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             branch,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [SEL_W-1:0] alusrcb,
  output logic [SEL_W-1:0] pcsrc,
  output logic [SEL_W-1:0] aluop,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  statetype_t state;
  statetype_t state_n;
  ctrl_t      ctrl;
  logic       mem_rdy_eff;

  assign mem_rdy_eff = WAIT_EN ? mem_ready : 1'b1;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Next-state sequencing; op is only consulted while the IR is stable.
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   if (mem_rdy_eff) state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = RTYPEEX;
          OP_BEQ:       state_n = BEQEX;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JEX;
          default:      state_n = FETCH;
        endcase
      end
      MEMADR:  state_n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_rdy_eff) state_n = MEMWB;
      MEMWB:   state_n = FETCH;
      MEMWR:   if (mem_rdy_eff) state_n = FETCH;
      RTYPEEX: state_n = RTYPEWB;
      RTYPEWB: state_n = FETCH;
      BEQEX:   state_n = FETCH;
      ADDIEX:  state_n = ADDIWB;
      ADDIWB:  state_n = FETCH;
      JEX:     state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_rdy_eff),
    .op        (op),
    .ctrl      (ctrl)
  );

  // Retired-instruction counter; wraps naturally, reset wins over increment.
  always_ff @(posedge clk) begin
    if (reset)            instret <= '0;
    else if (ctrl.retire) instret <= instret + CNT_W'(1);
  end

  assign pcwrite  = ctrl.pcwrite;
  assign branch   = ctrl.branch;
  assign iord     = ctrl.iord;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign retire   = ctrl.retire;
  assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: driver queues per-cycle expectations, monitor checks them.
module tb_mc_ctrl_fsm;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op;
  logic          mem_ready;
  logic          pcwrite, branch, iord, memwrite, irwrite, regdst;
  logic          memtoreg, regwrite, alusrca, retire, illegal;
  logic [1:0]    alusrcb, pcsrc, aluop;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.WAIT_EN(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .retire(retire), .illegal(illegal), .instret(instret)
  );

  typedef struct {
    logic [16:0]   w;
    logic [CW-1:0] cnt;
    int            id;
  } exp_t;

  exp_t          q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            step = 0;
  logic [CW-1:0] cnt_m;

  // Bit order: pcwrite branch iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc aluop retire illegal
  function automatic logic [16:0] cw(input int pcw, input int br, input int io, input int mw,
                                      input int irw, input int rd, input int m2r, input int rw,
                                      input int asa, input int asb, input int pcs, input int aop,
                                      input int ret, input int ill);
    return {1'(pcw), 1'(br), 1'(io), 1'(mw), 1'(irw), 1'(rd), 1'(m2r), 1'(rw),
            1'(asa), 2'(asb), 2'(pcs), 2'(aop), 1'(ret), 1'(ill)};
  endfunction

  logic [16:0] F1, F0, DEC, DILL, MADR, MRD, MWB, MWR0, MWR1, REX, RWB, BEQ, AEX, AWB, JX;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010, XX = 6'b111111;

  // One driven cycle: set inputs just after the edge and queue the outputs expected in it.
  task automatic cyc(input logic rst, input logic [5:0] o, input logic mr,
                     input logic [16:0] e, input bit chk);
    exp_t x;
    @(posedge clk); #1;
    reset = rst; op = o; mem_ready = mr;
    if (chk) begin
      x.w = e; x.cnt = cnt_m; x.id = step;
      q.push_back(x);
    end
    step++;
    if (rst)               cnt_m = '0;
    else if (chk && e[1])  cnt_m = cnt_m + CW'(1);
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  exp_t        mx;
  logic [16:0] got;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mx  = q.pop_front();
        got = {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, aluop, retire, illegal};
        n_chk++;
        if (got !== mx.w) begin
          n_fail++;
          $display("FAIL ctrl step %0d: got %b expected %b", mx.id, got, mx.w);
        end
        n_chk++;
        if (instret !== mx.cnt) begin
          n_fail++;
          $display("FAIL instret step %0d: got %0d expected %0d", mx.id, instret, mx.cnt);
        end
      end
    end
  end

  // Run-time bound in case the stimulus ever stalls.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1; op = RT; mem_ready = 1'b1; cnt_m = '0;
    F1   = cw(1,0,0,0,1,0,0,0,0,1,0,0,0,0);
    F0   = cw(0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    DEC  = cw(0,0,0,0,0,0,0,0,0,3,0,0,0,0);
    DILL = cw(0,0,0,0,0,0,0,0,0,3,0,0,0,1);
    MADR = cw(0,0,0,0,0,0,0,0,1,2,0,0,0,0);
    MRD  = cw(0,0,1,0,0,0,0,0,0,0,0,0,0,0);
    MWB  = cw(0,0,0,0,0,0,1,1,0,0,0,0,1,0);
    MWR0 = cw(0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    MWR1 = cw(0,0,1,1,0,0,0,0,0,0,0,0,1,0);
    REX  = cw(0,0,0,0,0,0,0,0,1,0,0,2,0,0);
    RWB  = cw(0,0,0,0,0,1,0,1,0,0,0,0,1,0);
    BEQ  = cw(0,1,0,0,0,0,0,0,1,0,1,1,1,0);
    AEX  = cw(0,0,0,0,0,0,0,0,1,2,0,0,0,0);
    AWB  = cw(0,0,0,0,0,0,0,1,0,0,0,0,1,0);
    JX   = cw(1,0,0,0,0,0,0,0,0,0,2,0,1,0);

    // Reset for two cycles; second cycle already shows FETCH and a cleared counter.
    cyc(1'b1, RT, 1'b1, F1, 1'b0);
    cyc(1'b1, RT, 1'b1, F1, 1'b1);

    // lw, no wait: five cycles, retire in MEMWB.
    cyc(1'b0, XX, 1'b1, F1,   1'b1);
    cyc(1'b0, LW, 1'b1, DEC,  1'b1);
    cyc(1'b0, LW, 1'b1, MADR, 1'b1);
    cyc(1'b0, XX, 1'b1, MRD,  1'b1);
    cyc(1'b0, XX, 1'b1, MWB,  1'b1);

    // sw with a fetch stall and three write wait cycles, single retire.
    cyc(1'b0, XX, 1'b0, F0,   1'b1);
    cyc(1'b0, XX, 1'b1, F1,   1'b1);
    cyc(1'b0, SW, 1'b1, DEC,  1'b1);
    cyc(1'b0, SW, 1'b1, MADR, 1'b1);
    cyc(1'b0, XX, 1'b0, MWR0, 1'b1);
    cyc(1'b0, LW, 1'b0, MWR0, 1'b1);
    cyc(1'b0, XX, 1'b0, MWR0, 1'b1);
    cyc(1'b0, XX, 1'b1, MWR1, 1'b1);

    // beq and j, three cycles each.
    cyc(1'b0, XX, 1'b1, F1,  1'b1);
    cyc(1'b0, BQ, 1'b1, DEC, 1'b1);
    cyc(1'b0, XX, 1'b1, BEQ, 1'b1);
    cyc(1'b0, XX, 1'b1, F1,  1'b1);
    cyc(1'b0, JJ, 1'b1, DEC, 1'b1);
    cyc(1'b0, XX, 1'b1, JX,  1'b1);

    // addi, four cycles.
    cyc(1'b0, XX, 1'b1, F1,  1'b1);
    cyc(1'b0, AI, 1'b1, DEC, 1'b1);
    cyc(1'b0, XX, 1'b1, AEX, 1'b1);
    cyc(1'b0, XX, 1'b1, AWB, 1'b1);

    // Illegal opcode: pulse in DECODE, straight back to FETCH, no count.
    cyc(1'b0, XX, 1'b1, F1,   1'b1);
    cyc(1'b0, XX, 1'b1, DILL, 1'b1);
    cyc(1'b0, XX, 1'b1, F1,   1'b1);

    // lw with one read wait cycle.
    cyc(1'b0, LW, 1'b1, DEC,  1'b1);
    cyc(1'b0, LW, 1'b1, MADR, 1'b1);
    cyc(1'b0, XX, 1'b0, MRD,  1'b1);
    cyc(1'b0, XX, 1'b1, MRD,  1'b1);
    cyc(1'b0, XX, 1'b1, MWB,  1'b1);

    // Sixteen R-type instructions carry the 4-bit counter through 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, XX, 1'b1, F1,  1'b1);
      cyc(1'b0, RT, 1'b1, DEC, 1'b1);
      cyc(1'b0, XX, 1'b1, REX, 1'b1);
      cyc(1'b0, XX, 1'b1, RWB, 1'b1);
    end

    // Reset during RTYPEEX: no writeback, no retire, counter cleared.
    cyc(1'b0, XX, 1'b1, F1,  1'b1);
    cyc(1'b0, RT, 1'b1, DEC, 1'b1);
    cyc(1'b1, XX, 1'b1, REX, 1'b1);
    cyc(1'b0, XX, 1'b1, F1,  1'b1);
    cyc(1'b0, JJ, 1'b1, DEC, 1'b1);
    cyc(1'b0, XX, 1'b1, JX,  1'b1);
    cyc(1'b0, XX, 1'b1, F1,  1'b1);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
